mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle controller for the RV32M multiply/divide unit. It sits beside the ALU in the execute stage.
- Accepts one M-extension op (Funct7 = 7'b0000001, any Funct3) from the ALUController/decode path.
- Runs an iterative shift-add multiply or restoring divide over XLEN cycles, stalling the pipeline through Busy.
- Returns a single-cycle Done pulse with the result; the ALU stays free for the other instructions.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
Start  input  1  request; sampled only in IDLE
Flush  input  1  pipeline kill; aborts any op in flight
Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  XLEN  rs1 operand (multiplicand/dividend)
SrcB  input  XLEN  rs2 operand (multiplier/divisor)
Ready  output  1  high only in IDLE
Busy  output  1  high in PREP, CALC, FIX; drives pipeline stall
Done  output  1  one-cycle pulse, Result valid
Result  output  XLEN  result; holds last value until next Done

Behaviour:
- Reset (async, reset_n=0): state IDLE, counter 0, all internal registers 0, Ready=1, Busy=0, Done=0, Result=0. Applies mid-operation; no Done is produced for the aborted op.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: when Start=1 and Flush=0, latch Funct3, SrcA and SrcB, then go to PREP. Start while not in IDLE is ignored; it is not queued.
- PREP, 1 cycle:
  - Compute operand signedness per Funct3 (MULH: both signed; MULHSU: A signed, B unsigned; DIV/REM: both signed; the rest unsigned).
  - Take absolute values and record the result sign.
  - Load counter = XLEN-1, then go to CALC.
  - Division by zero (B==0, DIV/DIVU/REM/REMU): Result = all ones for DIV/DIVU, Result = SrcA for REM/REMU; go to DONE.
  - Signed overflow (DIV/REM, A=0x8000_0000, B=0xFFFF_FFFF): DIV gives 0x8000_0000, REM gives 0; go to DONE.
- CALC, XLEN cycles:
  - Multiply: one shift-add step per cycle into a 2*XLEN product register.
  - Divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - Counter decrements each cycle; when counter==0, go to FIX.
- FIX, 1 cycle: negate the product or quotient if the result sign is set; the remainder takes the dividend sign. Select the output:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Register into Result, then go to DONE.
- DONE, 1 cycle: Done=1, Busy=0, Ready=0, then go to IDLE.
- Latency: the Start-accept edge is cycle 0; Done is high in cycle XLEN+3 (35 for XLEN=32). Special cases put Done high in cycle 2.
- Flush: from any state other than IDLE, go to IDLE on the next edge. No Done; Result is not updated. Flush in DONE still lets that cycle's Done through.
- Start and Flush together in IDLE: the op is not accepted.
- Counter width is clog2(XLEN). Arithmetic is two's complement. No wrap beyond the CALC terminal count.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined, multiply ops: CALC checks the remaining (shifted) multiplier bits each cycle. If they are all zero, the product register is shifted into final alignment in that cycle and the state goes to FIX. Latency becomes data dependent, with a minimum of 4 cycles. Divide ops are unchanged.
- Undefined: latency is fixed at XLEN+3 for every non-special op. The early-out logic is not synthesized.

Test Plan:
- Reset: hold reset_n=0, then release -> Ready=1, Busy=0, Done=0, Result=0. Drive reset_n low mid-CALC -> IDLE immediately, no Done.
- MUL 7 x -3 (Funct3=000, SrcA=7, SrcB=0xFFFF_FFFD) -> Done at cycle 35 with Result=0xFFFF_FFEB. MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE.
- DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2. All Done at cycle 35.
- DIVU 5/0 -> 0xFFFF_FFFF, REM 5/0 -> 5, DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000. All Done at cycle 2.
- Flush at cycle 10 of a DIV -> IDLE at cycle 11, no Done, Result keeps its prior value. A second Start at cycle 5 of any op -> ignored.
- MDU_EARLY_OUT_EN defined: MUL 0x1234 x 3 -> 0x369C with Done before cycle 35. Undefined -> Done exactly at cycle 35.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M multiply/divide controller (shift-add multiply, restoring divide).
// Optional MDU_EARLY_OUT_EN: multiply ops leave CALC as soon as the remaining multiplier bits are zero.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Ready,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   divisor;
  logic              res_neg;
  logic              rem_neg;

  logic              is_div;
  logic              a_signed;
  logic              b_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic              div_zero;
  logic              div_ovf;

  logic [2*XLEN-1:0] prod_step;
  logic [2*XLEN-1:0] mcand_step;
  logic [XLEN-1:0]   mplier_step;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   rem_step;
  logic [XLEN-1:0]   quo_step;
  logic              last_step;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  // Operand decode on the latched op; signedness follows the RV32M op table.
  always_comb begin
    is_div   = op[2];
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && opa[XLEN-1];
    b_neg    = b_signed && opb[XLEN-1];
    a_abs    = a_neg ? -opa : opa;
    b_abs    = b_neg ? -opb : opb;
    div_zero = is_div && (opb == '0);
    div_ovf  = is_div && !op[0] && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
  end

  // One multiply step (add shifted multiplicand) and one restoring divide step per cycle.
  always_comb begin
    prod_step   = mplier[0] ? (prod + mcand) : prod;
    mcand_step  = mcand << 1;
    mplier_step = mplier >> 1;
    shifted     = {rem, quo[XLEN-1]};
    trial       = shifted - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_step = trial[XLEN-1:0];
      quo_step = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_step = shifted[XLEN-1:0];
      quo_step = {quo[XLEN-2:0], 1'b0};
    end
  end

`ifdef MDU_EARLY_OUT_EN
  // The multiplicand is pre-shifted, so the product is already aligned when the multiplier runs out.
  assign last_step = (count == '0) || (!is_div && (mplier_step == '0));
`else
  assign last_step = (count == '0);
`endif

  always_comb begin
    prod_fix = res_neg ? -prod : prod;
    quo_fix  = res_neg ? -quo : quo;
    rem_fix  = rem_neg ? -rem : rem;
    case (op)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      op      <= '0;
      opa     <= '0;
      opb     <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      Ready   <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= '0;
    end else if (state == IDLE) begin
      Done <= 1'b0;
      if (Start && !Flush) begin
        op    <= Funct3;
        opa   <= SrcA;
        opb   <= SrcB;
        state <= PREP;
        Ready <= 1'b0;
        Busy  <= 1'b1;
      end
    end else if (Flush) begin
      // Abandon the op; Result keeps whatever it last delivered.
      state <= IDLE;
      Ready <= 1'b1;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        PREP: begin
          if (div_zero) begin
            Result <= op[1] ? opa : '1;
            state  <= DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
          end else if (div_ovf) begin
            Result <= op[1] ? '0 : opa;
            state  <= DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
          end else begin
            count   <= CW'(XLEN - 1);
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            prod    <= '0;
            mcand   <= {{XLEN{1'b0}}, a_abs};
            mplier  <= b_abs;
            rem     <= '0;
            quo     <= a_abs;
            divisor <= b_abs;
            state   <= CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            rem <= rem_step;
            quo <= quo_step;
          end else begin
            prod   <= prod_step;
            mcand  <= mcand_step;
            mplier <= mplier_step;
          end
          if (last_step) begin
            state <= FIX;
          end else begin
            count <= count - CW'(1);
          end
        end
        FIX: begin
          Result <= fix_result;
          state  <= DONE;
          Busy   <= 1'b0;
          Done   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b1;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: arithmetic reference model checked every cycle, plus hand-computed vectors.
module tb_mdu_sequencer;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Ready;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Flush(Flush),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  // Result of an RV32M op from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    bit ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Cycle (accept cycle = 0) in which Done is expected.
  function automatic int ref_len(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mb;
    int steps;
    if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    if (EO && !f3[2]) begin
      mb = (f3 == 3'b001 && b[31]) ? -b : b;
      steps = 1;
      for (int i = 0; i < 32; i++) if (mb[i]) steps = i + 1;
      return steps + 3;
    end
    return 35;
  endfunction

  logic        m_active = 1'b0;
  int          m_cyc = 0;
  int          m_len = 0;
  logic [31:0] m_pend = '0;
  logic        m_ready = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0; m_cyc <= 0; m_ready <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0; m_result <= '0;
    end else if (!m_active) begin
      if (Start && !Flush) begin
        m_active <= 1'b1; m_cyc <= 1;
        m_len <= ref_len(Funct3, SrcA, SrcB);
        m_pend <= ref_result(Funct3, SrcA, SrcB);
        m_ready <= 1'b0; m_busy <= 1'b1;
      end
    end else if (Flush || m_cyc == m_len) begin
      m_active <= 1'b0; m_ready <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_cyc + 1 == m_len) begin
      m_cyc <= m_cyc + 1; m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pend;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      vectors++;
      if ({Ready, Busy, Done, Result} !== {m_ready, m_busy, m_done, m_result}) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got rdy/busy/done=%b%b%b result=%h, required %b%b%b result=%h",
                 $time, Ready, Busy, Done, Result, m_ready, m_busy, m_done, m_result);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc, input int flush_at, input int restart_at);
    int cyc;
    int done_cyc;
    bit fin;
    @(negedge clk);
    Start = 1'b1; Funct3 = f3; SrcA = a; SrcB = b;
    cyc = 0; done_cyc = -1; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      Start = 1'b0; Flush = 1'b0;
      if (cyc == restart_at) begin
        Start = 1'b1; Funct3 = 3'b101; SrcA = 32'd9; SrcB = 32'd3;
      end
      if (Done) begin
        done_cyc = cyc;
        check({name, "_result"}, Result, exp_res);
      end
      if (cyc == flush_at) Flush = 1'b1;
      if (Ready && cyc > 1) fin = 1'b1;
      if (cyc > 60) begin
        vectors++; miscompares++;
        $display("FAIL %s_timeout got no return to Ready within 60 cycles", name);
        fin = 1'b1;
      end
    end
    check({name, "_done_cycle"}, done_cyc, exp_cyc);
    if (flush_at > 0) begin
      check({name, "_idle_cycle"}, cyc, flush_at + 1);
      check({name, "_result_kept"}, Result, exp_res);
    end
    $display("op %s f3=%b a=%h b=%h done_cycle=%0d result=%h", name, f3, a, b, done_cyc, Result);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, Ready}, 32'd1);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_done", {31'b0, Done}, 32'd0);
    check("reset_result", Result, 32'd0);
    #2 reset_n = 1'b1;
    checking = 1'b1;

    run_op("mul_7_m3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0, 0);
    run_op("mulhu_max",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0, 0);
    run_op("mulh_m7_2",     3'b001, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, EO ? 5 : 35, 0, 0);
    run_op("mulhsu_min",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 0, 0);
    run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 35, 0, 0);
    run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 35, 0, 0);
    run_op("divu_100_7",    3'b101, 32'd100,        32'd7,          32'd14,        35, 0, 0);
    run_op("remu_100_7",    3'b111, 32'd100,        32'd7,          32'd2,         35, 0, 0);
    run_op("divu_5_0",      3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 2, 0, 0);
    run_op("rem_5_0",       3'b110, 32'd5,          32'd0,          32'd5,         2, 0, 0);
    run_op("div_ovf",       3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0, 0);
    run_op("rem_ovf",       3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2, 0, 0);
    run_op("divu_100_7b",   3'b101, 32'd100,        32'd7,          32'd14,        35, 0, 0);
    run_op("div_flushed",   3'b100, 32'd1000,       32'd7,          32'd14,        -1, 10, 0);
    run_op("mul_restart",   3'b000, 32'h0000_1234, 32'd3,          32'h0000_369C, EO ? 5 : 35, 0, 5);

    // Reset in the middle of CALC: outputs return to reset values and no Done follows.
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'b100; SrcA = 32'd1000; SrcB = 32'd7;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    check("midreset_ready", {31'b0, Ready}, 32'd1);
    check("midreset_busy", {31'b0, Busy}, 32'd0);
    check("midreset_done", {31'b0, Done}, 32'd0);
    check("midreset_result", Result, 32'd0);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("midreset_no_done", {31'b0, Done}, 32'd0);
    end
    $display("op midreset ready=%b result=%h", Ready, Result);

    run_op("remu_after_rst", 3'b111, 32'd100,       32'd7,          32'd2,         35, 0, 0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
